pipelined_cla_subtractor: RTL and testbench
===========================================

Name: pipelined_cla_subtractor

Overview:
- WIDTH-bit two's-complement subtractor computing D = A - B as A + ~B + 1.
- Built from 4-bit carry-lookahead groups: in-group generate/propagate, lookahead carries, per-group G/P.
- One group is evaluated per pipeline stage. The group carry is registered between stages.
- Valid/ready handshake on input and output; sits on the datapath behind operand registers and ahead of result/flag consumers.

Parameters:
- WIDTH, 16, operand width. Must be a multiple of 4 and at least 4.
- STAGES, WIDTH/4, pipeline depth (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  A - B modulo 2^WIDTH.
- borrow  output  1  1 when A < B unsigned (inverse of final carry).
- ovf  output  1  signed overflow.
- zero  output  1  diff == 0.
- lt_s  output  1  A < B signed (diff MSB xor ovf).

Behaviour:
- Reset: synchronous on clk when rst=1. All stage valid bits cleared. out_valid=0. diff, borrow, ovf, zero and lt_s = 0. in_ready=1 in the cycle after reset.
- rst overrides all handshakes. Data in flight is discarded, with no partial output.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - a and b are sampled only on an input transfer.
- Stall: global. stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, every stage register holds and outputs stay stable.
  - No bubble collapsing.
- Stage 0:
  - Group 0 (bits 3:0) uses carry-in = 1.
  - Registers group-0 sum bits, group-0 carry-out, remaining operand bits of a and ~b, and a[MSB], b[MSB].
- Stage k (1..STAGES-1):
  - Group k (bits 4k+3:4k) uses the registered carry from stage k-1.
  - In-group carries: c(i+1) = g(i) | p(i)&c(i), fully expanded lookahead (no ripple inside the group). g = a&~b, p = a^~b.
  - Sum bit = p ^ carry-in for that bit.
- Latency: operands accepted at edge t appear with out_valid=1 after edge t+STAGES-1 (STAGES cycles including the accept cycle), absent stalls.
  - With STAGES=1 the result is registered once; latency is 1.
- Throughput: one operation per cycle when out_ready is held high.
- Output stage valid is set when the last stage captures valid data, and cleared on output transfer with no new data arriving.
- Flags, computed from the final-stage values:
  - borrow = ~c_out.
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb).
  - zero = ~|diff.
  - lt_s = diff_msb ^ ovf.
- Ordering: results emerge in acceptance order. No reordering; no drop except on reset.
- in_valid=0 inserts bubbles. Bubble stages carry valid=0; their data contents are don't-care, but outputs must not change while out_valid=0 is held.
- Simultaneous output transfer and new input: both occur in the same cycle; the pipeline advances.

Test Plan:
- WIDTH=16. a=0x0005, b=0x0003 -> after 4 cycles diff=0x0002, borrow=0, ovf=0, zero=0, lt_s=0.
- a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, lt_s=1. Then a=0x1234, b=0x1234 -> diff=0x0000, zero=1, borrow=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, lt_s=1, borrow=0. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, lt_s=0, borrow=1.
- Feed 8 back-to-back pairs (a=i*0x1111, b=0x0F0F) with out_ready=1 -> 8 consecutive out_valid cycles, correct in order, starting 4 cycles after the first accept.
- Drop out_ready for 3 cycles while the pipe is full -> in_ready=0 and outputs frozen for those cycles; no loss or duplication after release.
- Assert rst for 1 cycle with 3 ops in flight -> next cycle out_valid=0 and all outputs 0. A new op afterward completes normally with the correct result.

Source files
------------

// File: rtl/pipelined_cla_subtractor.sv
// Pipelined two's-complement subtractor: diff = a - b, computed as a + ~b + 1.
// The operands are split into 4-bit carry-lookahead groups, and each pipeline
// stage evaluates one group. The carry out of a group is registered and feeds
// the next stage. The final stage registers the result and the comparison flags.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b are sampled on transfer)
//   a, b                  minuend, subtrahend (WIDTH bits)
//   out_valid / out_ready result handshake
//   diff                  a - b modulo 2^WIDTH
//   borrow                a < b unsigned
//   ovf                   signed overflow of the subtraction
//   zero                  diff == 0
//   lt_s                  a < b signed
//
// WIDTH must be a multiple of 4 and at least 4. Pipeline depth = WIDTH/4.

module pipelined_cla_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             lt_s
);

    localparam int unsigned STAGES = WIDTH / 4;
    // Inter-stage register count; kept at least 1 so the arrays stay legal
    // when the whole subtractor is a single stage.
    localparam int unsigned NPIPE  = (STAGES > 1) ? STAGES - 1 : 1;

    // 4-bit carry-lookahead group. Returns {carry_out, sum[3:0]}.
    // Every carry is a flat sum of products of g/p and the group carry-in.
    function automatic logic [4:0] cla_group(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       grp_g;
        logic       grp_p;
        logic       c4;
        g     = x & y;
        p     = x ^ y;
        c1    = g[0] | (p[0] & cin);
        c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        c4    = grp_g | (grp_p & cin);
        return {c4, p ^ {c3, c2, c1, cin}};
    endfunction

    // Global stall: the whole pipe freezes while a result waits at the output.
    logic advance;
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    // Per-stage valid bits; the last one is the output valid.
    logic vld [STAGES];
    assign out_valid = vld[STAGES-1];

    // Inter-stage registers. Operands are shifted right by one group per
    // stage so the group being evaluated always sits in bits [3:0]. Sum bits
    // enter from the top and shift down, ending fully aligned after the last
    // stage.
    logic [WIDTH-1:0] a_q    [NPIPE];
    logic [WIDTH-1:0] nb_q   [NPIPE];
    logic [WIDTH-1:0] sum_q  [NPIPE];
    logic             c_q    [NPIPE];
    logic             amsb_q [NPIPE];
    logic             bmsb_q [NPIPE];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [3:0]       x_nib;
        logic [3:0]       y_nib;
        logic             cin;
        logic             vin;
        logic             amsb;
        logic             bmsb;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum_nx;
        logic [4:0]       grp;

        // Stage inputs: raw operands for stage 0, previous registers otherwise.
        if (k == 0) begin : g_src
            assign x_nib  = a[3:0];
            assign y_nib  = ~b[3:0];
            assign cin    = 1'b1;
            assign vin    = in_valid;
            assign amsb   = a[WIDTH-1];
            assign bmsb   = b[WIDTH-1];
            assign sum_in = '0;
        end else begin : g_src
            assign x_nib  = a_q[k-1][3:0];
            assign y_nib  = nb_q[k-1][3:0];
            assign cin    = c_q[k-1];
            assign vin    = vld[k-1];
            assign amsb   = amsb_q[k-1];
            assign bmsb   = bmsb_q[k-1];
            assign sum_in = sum_q[k-1];
        end

        assign grp    = cla_group(x_nib, y_nib, cin);
        assign sum_nx = (sum_in >> 4) | (WIDTH'(grp[3:0]) << (WIDTH - 4));

        // Valid bit of this stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld[k] <= 1'b0;
            end else if (advance) begin
                vld[k] <= vin;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_nx;
            logic [WIDTH-1:0] nb_nx;

            if (k == 0) begin : g_op
                assign a_nx  = a >> 4;
                assign nb_nx = (~b) >> 4;
            end else begin : g_op
                assign a_nx  = a_q[k-1] >> 4;
                assign nb_nx = nb_q[k-1] >> 4;
            end

            // Data loads only with valid data so bubbles leave contents untouched.
            always_ff @(posedge clk) begin
                if (advance && vin) begin
                    a_q[k]    <= a_nx;
                    nb_q[k]   <= nb_nx;
                    sum_q[k]  <= sum_nx;
                    c_q[k]    <= grp[4];
                    amsb_q[k] <= amsb;
                    bmsb_q[k] <= bmsb;
                end
            end
        end else begin : g_last
            logic ovf_nx;
            assign ovf_nx = (amsb != bmsb) && (sum_nx[WIDTH-1] != amsb);

            // Result and flag registers; hold across bubbles and stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    diff   <= '0;
                    borrow <= 1'b0;
                    ovf    <= 1'b0;
                    zero   <= 1'b0;
                    lt_s   <= 1'b0;
                end else if (advance && vin) begin
                    diff   <= sum_nx;
                    borrow <= ~grp[4];
                    ovf    <= ovf_nx;
                    zero   <= ~|sum_nx;
                    lt_s   <= sum_nx[WIDTH-1] ^ ovf_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Scoreboard bench for pipelined_cla_subtractor (WIDTH=16, 4 stages).
// The driver pushes hand-computed expected results on each input transfer;
// an independent monitor pops and compares on each output transfer.

module tb_pipelined_cla_subtractor;

    localparam int unsigned WIDTH = 16;
    localparam int          LAT   = 3;   // edges from accept edge to out_valid
    localparam int          NVEC  = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;
    logic             lt_s;

    pipelined_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero),
        .lt_s      (lt_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors; expected = {diff, borrow, ovf, zero, lt_s}.
    logic [15:0] va [NVEC] = '{16'h0005, 16'h0003, 16'h1234, 16'h8000, 16'h7FFF,
                               16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                               16'h5555, 16'h6666, 16'h7777, 16'hFFFF, 16'h0000,
                               16'hABCD, 16'h0001};
    logic [15:0] vb [NVEC] = '{16'h0003, 16'h0005, 16'h1234, 16'h0001, 16'hFFFF,
                               16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F,
                               16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0000, 16'h8000,
                               16'h1234, 16'h0001};
    logic [19:0] vr [NVEC] = '{20'h0002_0, 20'hFFFE_9, 20'h0000_2, 20'h7FFF_5,
                               20'h8000_C, 20'hF0F1_9, 20'h0202_0, 20'h1313_0,
                               20'h2424_0, 20'h3535_0, 20'h4646_0, 20'h5757_0,
                               20'h6868_0, 20'hFFFF_1, 20'h8000_C, 20'h9999_1,
                               20'h0000_2};

    typedef struct {
        logic [19:0] res;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [19:0] dut_res();
        return {diff, borrow, ovf, zero, lt_s};
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_outputs"}, 32'(dut_res()), 32'd0);
    endtask

    // Present one vector and hold it until accepted; pushes the expectation.
    task automatic send(input int idx, input bit chk_lat);
        exp_t e;
        int   waits;
        a        = va[idx];
        b        = vb[idx];
        in_valid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        check("accept", 32'(in_ready), 32'd1);
        if (in_ready) begin
            e.res     = vr[idx];
            e.acc     = cyc + 1;
            e.chk_lat = chk_lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while (exp_q.size() != 0 && waits < 60) begin
            waits++;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output transfer against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got %0h expected no output", dut_res());
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(dut_res()), 32'(e.res));
                    if (e.chk_lat) check("latency", 32'(cyc - e.acc), 32'(LAT));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        // Basic subtract, borrow/equality, and signed overflow pairs.
        send(0, 1'b1); in_valid = 1'b0; drain();
        send(1, 1'b1); send(2, 1'b1); in_valid = 1'b0; drain();
        send(3, 1'b1); send(4, 1'b1); in_valid = 1'b0; drain();

        // Eight back-to-back operations at full throughput.
        for (int i = 5; i <= 12; i++) send(i, 1'b1);
        in_valid = 1'b0;
        drain();

        // Fill the pipe, then stall the output for 3 cycles with new data offered.
        for (int i = 13; i <= 16; i++) send(i, 1'b0);
        out_ready = 1'b0;
        a         = va[0];
        b         = vb[0];
        in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(dut_res()), 32'(exp_q[0].res));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight discards them.
        send(0, 1'b0); send(1, 1'b0); send(2, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("midrst");
        exp_q.delete();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Fresh operation completes normally; outputs then hold through bubbles.
        send(15, 1'b1);
        in_valid = 1'b0;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("bubble_hold", 32'({out_valid, dut_res()}), 32'({1'b0, vr[15]}));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
